// File: rtl/dmem_mmio_bridge.sv
// rtl/dmem_mmio_bridge.sv - processor data-port decoder for RAM and game MMIO peripherals
//
// Routes each processor data access either to the data RAM (upper half-word
// 0x0000) or to the memory-mapped peripherals (upper half-word 0xFFFF).
// Every region answers with the same one-cycle read latency as the RAM.
//
// MMIO offsets (proc_addr[3:0]):
//   0x0 BTN_STATUS  R   [3:0] sticky press flags, [7:4] live button levels
//   0x1 BTN_CLEAR   W   clear the flags selected by wdata[3:0]
//   0x2 TIMER       R   32-bit millisecond tick count
//   0x3 TIMER_CTRL  RW  bit0 run, bit1 clear strobe (reads 0)
//   0x4 DISP_DATA   W   push wdata into the display FIFO
//   0x5 DISP_STATUS RW  bit0 full, bit1 empty, bit2 overflow, [7:4] count;
//                       writing bit2=1 clears overflow
//
// Ports:
//   clock, reset       master clock, asynchronous active-low reset
//   proc_addr/wdata/wren/q   processor data port (word addresses)
//   ram_addr/wdata/wren/q    data RAM port (ram_q registered by the RAM)
//   btn_in             raw asynchronous push-button levels
//   disp_data/valid/ready    display FIFO head, consumed on valid & ready
//
// Optional build macro: BTN_DEBOUNCE_EN adds a per-button debounce filter
// of DEBOUNCE_CYCLES stable cycles after the synchronizer.

module dmem_mmio_bridge #(
    parameter int RAM_AW          = 12,
    parameter int TIMER_DIV       = 50000,
    parameter int FIFO_DEPTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       proc_addr,
    input  logic [31:0]       proc_wdata,
    input  logic              proc_wren,
    output logic [31:0]       proc_q,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    input  logic [3:0]        btn_in,
    output logic [31:0]       disp_data,
    output logic              disp_valid,
    input  logic              disp_ready
);

    localparam int PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Address decode
    logic ramSel, mmioSel, mmioWr;
    logic [3:0] mmioOff;
    logic unusedAddrBits;

    assign ramSel    = (proc_addr[31:16] == 16'h0000);
    assign mmioSel   = (proc_addr[31:16] == 16'hFFFF);
    assign mmioOff   = proc_addr[3:0];
    assign mmioWr    = proc_wren & mmioSel;
    assign ram_addr  = proc_addr[RAM_AW-1:0];
    assign ram_wdata = proc_wdata;
    assign ram_wren  = proc_wren & ramSel;
    // Middle address bits select nothing; fold them so every bit is consumed.
    assign unusedAddrBits = ^proc_addr;

    logic wrBtnClr, wrTimerCtrl, wrDispData, wrDispStat;
    assign wrBtnClr    = mmioWr && (mmioOff == 4'h1);
    assign wrTimerCtrl = mmioWr && (mmioOff == 4'h3);
    assign wrDispData  = mmioWr && (mmioOff == 4'h4);
    assign wrDispStat  = mmioWr && (mmioOff == 4'h5);

    // Buttons
    logic [3:0] btnSync1, btnSync2, btnLevel, btnPrev, btnFlags, btnRise, btnClrMask;

`ifdef BTN_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] dbCount [4];
    logic [3:0]      btnFilt;

    // The filtered level follows the synchronized level only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btnFilt <= '0;
            for (int i = 0; i < 4; i++) dbCount[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btnSync2[i] != btnFilt[i]) begin
                    if (dbCount[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        btnFilt[i] <= btnSync2[i];
                        dbCount[i] <= '0;
                    end else begin
                        dbCount[i] <= dbCount[i] + DB_W'(1);
                    end
                end else begin
                    dbCount[i] <= '0;
                end
            end
        end
    end
    assign btnLevel = btnFilt;
`else
    assign btnLevel = btnSync2;
`endif

    assign btnRise    = btnLevel & ~btnPrev;
    assign btnClrMask = wrBtnClr ? proc_wdata[3:0] : 4'b0000;

    // Timer
    logic [PRE_W-1:0] prescaler;
    logic [31:0]      timerCount;
    logic             timerRun, timerClear;
    assign timerClear = wrTimerCtrl & proc_wdata[1];

    // Display FIFO
    logic [31:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] fifoCount;
    logic             fifoFull, fifoEmpty, fifoOverflow, push, pop;
    logic [3:0]       countSat;

    assign fifoFull   = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty  = (fifoCount == '0);
    assign pop        = !fifoEmpty && disp_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = wrDispData && (!fifoFull || pop);
    assign disp_valid = !fifoEmpty;
    assign disp_data  = fifoEmpty ? 32'h0 : fifoMem[rdPtr];

    always_comb begin
        countSat = 4'(fifoCount);
        if (32'(fifoCount) > 32'd15) countSat = 4'hF;
    end

    // Read path: MMIO word is sampled with the address so it lines up with ram_q.
    logic [31:0] mmioWord, readData;
    logic        selRam;

    always_comb begin
        mmioWord = 32'h0;
        if (mmioSel) begin
            case (mmioOff)
                4'h0:    mmioWord = {24'h0, btnLevel, btnFlags};
                4'h2:    mmioWord = timerCount;
                4'h3:    mmioWord = {31'h0, timerRun};
                4'h5:    mmioWord = {24'h0, countSat, 1'b0, fifoOverflow, fifoEmpty, fifoFull};
                default: mmioWord = 32'h0;
            endcase
        end
    end

    assign proc_q = selRam ? ram_q : readData;

    always_ff @(posedge clock) begin
        if (push) fifoMem[wrPtr] <= proc_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            selRam       <= 1'b0;
            readData     <= 32'h0;
            btnSync1     <= '0;
            btnSync2     <= '0;
            btnPrev      <= '0;
            btnFlags     <= '0;
            prescaler    <= '0;
            timerCount   <= 32'h0;
            timerRun     <= 1'b0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            fifoCount    <= '0;
            fifoOverflow <= 1'b0;
        end else begin
            selRam   <= ramSel;
            readData <= mmioWord;

            btnSync1 <= btn_in;
            btnSync2 <= btnSync1;
            btnPrev  <= btnLevel;
            // New press wins over a simultaneous clear of the same bit.
            btnFlags <= (btnFlags & ~btnClrMask) | btnRise;

            if (wrTimerCtrl) timerRun <= proc_wdata[0];
            if (timerClear) begin
                prescaler  <= '0;
                timerCount <= 32'h0;
            end else if (timerRun) begin
                if (prescaler == PRE_W'(TIMER_DIV - 1)) begin
                    prescaler  <= '0;
                    timerCount <= timerCount + 32'd1;
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end

            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
            if (wrDispData && fifoFull && !pop) fifoOverflow <= 1'b1;
            else if (wrDispStat && proc_wdata[2]) fifoOverflow <= 1'b0;
        end
    end

endmodule
